// File: rtl/motion_pkg.sv
// Shared types for the motion segment scheduler: FSM states and the queued segment record.
package motion_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SETPOS
    } state_e;

    localparam int unsigned SEG_W            = 64;
    localparam int unsigned TICK_DIV_DEFAULT = 1000;

    typedef struct packed {
        logic signed [31:0] vel;
        logic        [31:0] dur;
    } seg_t;

endpackage

// File: rtl/seg_fifo.sv
// Zero-latency segment FIFO: head is always presented, push/pop/flush, registered count and ready.
module seg_fifo
    import motion_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [SEG_W-1:0]         wdata,
    output logic [SEG_W-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [SEG_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;

    // Ready reflects the pre-cycle count, so a full queue refuses a push even when popping.
    always_comb begin
        do_push  = push && ready_q && !flush;
        do_pop   = pop && (count_q != '0) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (!do_push && do_pop) count_d = count_q - CW'(1);
        end
        ready_d = (count_d < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign ready = ready_q;

endmodule

// File: rtl/motion_seq.sv
// Segment scheduler for one step_gen channel: plays queued (velocity, duration) segments
// back-to-back, zeroes velocity when drained, and grants position presets only when idle.
module motion_seq
    import motion_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     seg_valid,
    output logic                     seg_ready,
    input  logic [31:0]              seg_vel,
    input  logic [31:0]              seg_dur,
    input  logic                     setpos_req,
    input  logic [31:0]              setpos_value,
    input  logic                     abort,
    output logic [31:0]              velocity,
    output logic [31:0]              data_in,
    output logic                     set_position,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     seg_done,
    output logic                     setpos_err
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_e           state_q, state_d;
    logic [31:0]      vel_q, vel_d;
    logic [31:0]      data_q, data_d;
    logic             setpos_q, setpos_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             zdone_q, zdone_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [31:0]      rem_q, rem_d;
    logic             pop;
    logic [SEG_W-1:0] head_raw;
    seg_t             head;

    assign head = seg_t'(head_raw);

    seg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (seg_valid && !abort),
        .pop   (pop),
        .flush (abort),
        .wdata ({seg_vel, seg_dur}),
        .head  (head_raw),
        .count (count),
        .ready (seg_ready)
    );

    // A zero-duration segment popped at a RUN boundary gets its own done pulse one cycle later.
    always_comb begin
        state_d  = state_q;
        vel_d    = vel_q;
        data_d   = data_q;
        setpos_d = 1'b0;
        done_d   = zdone_q;
        err_d    = 1'b0;
        zdone_d  = 1'b0;
        tick_d   = tick_q;
        rem_d    = rem_q;
        pop      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (count != '0) begin
                    pop   = 1'b1;
                    err_d = setpos_req;
                    if (head.dur != '0) begin
                        vel_d   = head.vel;
                        rem_d   = head.dur;
                        tick_d  = '0;
                        state_d = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (setpos_req) begin
                    data_d   = setpos_value;
                    setpos_d = 1'b1;
                    state_d  = ST_SETPOS;
                end
            end
            ST_SETPOS: begin
                err_d   = setpos_req;
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                err_d = setpos_req;
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    rem_d  = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        done_d = 1'b1;
                        if (count != '0) begin
                            pop = 1'b1;
                            if (head.dur != '0) begin
                                vel_d = head.vel;
                                rem_d = head.dur;
                            end else begin
                                vel_d   = '0;
                                zdone_d = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end else begin
                            vel_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d  = ST_IDLE;
            vel_d    = '0;
            setpos_d = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b0;
            zdone_d  = 1'b0;
            tick_d   = '0;
            rem_d    = '0;
            pop      = 1'b0;
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            vel_q    <= '0;
            data_q   <= '0;
            setpos_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            zdone_q  <= 1'b0;
            tick_q   <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            vel_q    <= vel_d;
            data_q   <= data_d;
            setpos_q <= setpos_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            zdone_q  <= zdone_d;
            tick_q   <= tick_d;
            rem_q    <= rem_d;
        end
    end

    assign velocity     = vel_q;
    assign data_in      = data_q;
    assign set_position = setpos_q;
    assign busy         = busy_q;
    assign seg_done     = done_q;
    assign setpos_err   = err_q;

endmodule

// File: tb/tb_motion_seq.sv
// Directed bench for motion_seq with TICK_DIV=4, DEPTH=4; expectations are hand-derived.
module tb_motion_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        seg_valid;
    logic        seg_ready;
    logic [31:0] seg_vel;
    logic [31:0] seg_dur;
    logic        setpos_req;
    logic [31:0] setpos_value;
    logic        abort;
    logic [31:0] velocity;
    logic [31:0] data_in;
    logic        set_position;
    logic        busy;
    logic [2:0]  count;
    logic        seg_done;
    logic        setpos_err;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int done_base;

    motion_seq #(.DEPTH(4), .TICK_DIV(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .seg_valid    (seg_valid),
        .seg_ready    (seg_ready),
        .seg_vel      (seg_vel),
        .seg_dur      (seg_dur),
        .setpos_req   (setpos_req),
        .setpos_value (setpos_value),
        .abort        (abort),
        .velocity     (velocity),
        .data_in      (data_in),
        .set_position (set_position),
        .busy         (busy),
        .count        (count),
        .seg_done     (seg_done),
        .setpos_err   (setpos_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (seg_done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic hold_vel(input string tag, input logic [31:0] v, input int k);
        for (int i = 0; i < k; i++) begin
            tick();
            chk(tag, velocity, v);
        end
    endtask

    task automatic push_seg(input logic [31:0] v, input logic [31:0] d);
        seg_valid = 1'b1;
        seg_vel   = v;
        seg_dur   = d;
        tick();
        seg_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; seg_valid = 1'b0; seg_vel = '0; seg_dur = '0;
        setpos_req = 1'b0; setpos_value = '0; abort = 1'b0;
        tick(); tick();
        chk("rst_velocity", velocity, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(seg_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_setpos", 32'(set_position), 0);
        chk("rst_data_in", data_in, 0);
        reset = 1'b0;
        tick();

        // single segment {1000,3}
        done_base = done_cnt;
        push_seg(32'd1000, 32'd3);
        chk("s1_count_after_push", 32'(count), 1);
        chk("s1_vel_before_pop", velocity, 0);
        tick();
        chk("s1_vel_start", velocity, 1000);
        chk("s1_busy_start", 32'(busy), 1);
        chk("s1_count_popped", 32'(count), 0);
        hold_vel("s1_vel_hold", 32'd1000, 11);
        chk("s1_no_early_done", 32'(seg_done), 0);
        tick();
        chk("s1_vel_end", velocity, 0);
        chk("s1_done_pulse", 32'(seg_done), 1);
        chk("s1_busy_end", 32'(busy), 0);
        tick();
        chk("s1_done_one_cycle", 32'(seg_done), 0);
        chk("s1_done_total", 32'(done_cnt - done_base), 1);

        // back-to-back with a zero-duration segment in the middle
        done_base = done_cnt;
        push_seg(32'd500, 32'd2);
        push_seg(-32'sd700, 32'd1);
        chk("s2_vel_first", velocity, 500);
        push_seg(32'd0, 32'd0);
        push_seg(32'd300, 32'd1);
        chk("s2_count_queued", 32'(count), 3);
        hold_vel("s2_vel_500", 32'd500, 5);
        hold_vel("s2_vel_m700", -32'sd700, 4);
        tick();
        chk("s2_vel_zero", velocity, 0);
        chk("s2_busy_zero", 32'(busy), 0);
        chk("s2_done_at_zero", 32'(seg_done), 1);
        hold_vel("s2_vel_300", 32'd300, 4);
        tick();
        chk("s2_vel_final", velocity, 0);
        chk("s2_busy_final", 32'(busy), 0);
        tick();
        chk("s2_done_total", 32'(done_cnt - done_base), 4);

        // fill the queue while a long segment plays
        push_seg(32'd7, 32'd100);
        tick();
        chk("s3_running", 32'(busy), 1);
        seg_valid = 1'b1; seg_vel = 32'd1; seg_dur = 32'd1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("s3_count_fill", 32'(count), 32'(i));
        end
        chk("s3_ready_full", 32'(seg_ready), 0);
        tick();
        chk("s3_fifth_dropped", 32'(count), 4);
        seg_valid = 1'b0;
        for (int i = 0; i < 500 && seg_done !== 1'b1; i++) tick();
        chk("s3_done_seen", 32'(seg_done), 1);
        chk("s3_count_after_pop", 32'(count), 3);
        chk("s3_ready_after_pop", 32'(seg_ready), 1);
        chk("s3_next_vel", velocity, 1);

        // abort mid-segment with 3 queued
        tick();
        abort = 1'b1;
        seg_valid = 1'b1; seg_vel = 32'd42; seg_dur = 32'd5;
        done_base = done_cnt;
        tick();
        abort = 1'b0; seg_valid = 1'b0;
        chk("s5_abort_vel", velocity, 0);
        chk("s5_abort_count", 32'(count), 0);
        chk("s5_abort_busy", 32'(busy), 0);
        chk("s5_abort_ready", 32'(seg_ready), 1);
        chk("s5_abort_no_done", 32'(seg_done), 0);
        tick(); tick();
        chk("s5_abort_stays_idle", 32'(busy), 0);
        chk("s5_abort_done_total", 32'(done_cnt - done_base), 0);

        // position preset while idle, then while running
        setpos_req = 1'b1; setpos_value = 32'd12345;
        tick();
        setpos_req = 1'b0;
        chk("s4_setpos_high", 32'(set_position), 1);
        chk("s4_data_in", data_in, 12345);
        chk("s4_no_err", 32'(setpos_err), 0);
        tick();
        chk("s4_setpos_low", 32'(set_position), 0);
        chk("s4_data_hold", data_in, 12345);
        push_seg(32'd5, 32'd2);
        tick();
        chk("s4_run_busy", 32'(busy), 1);
        setpos_req = 1'b1; setpos_value = 32'd999;
        tick();
        setpos_req = 1'b0;
        chk("s4_run_err", 32'(setpos_err), 1);
        chk("s4_run_no_setpos", 32'(set_position), 0);
        chk("s4_run_data_hold", data_in, 12345);
        tick();
        chk("s4_err_one_cycle", 32'(setpos_err), 0);

        // reset mid-RUN with a push in flight
        seg_valid = 1'b1; seg_vel = 32'd9; seg_dur = 32'd9;
        reset = 1'b1;
        tick();
        reset = 1'b0; seg_valid = 1'b0;
        chk("s6_rst_vel", velocity, 0);
        chk("s6_rst_data_in", data_in, 0);
        chk("s6_rst_count", 32'(count), 0);
        chk("s6_rst_busy", 32'(busy), 0);
        chk("s6_rst_ready", 32'(seg_ready), 1);
        chk("s6_rst_done", 32'(seg_done), 0);
        tick(); tick();
        chk("s6_queue_empty", 32'(count), 0);
        chk("s6_stays_idle", 32'(busy), 0);
        chk("s6_vel_zero", velocity, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/motion_seq.md
# motion_seq

Segment scheduler that sits in front of one `step_gen` channel and sequences its `velocity`, `data_in` and `set_position` inputs. Host logic pushes timed velocity segments (velocity, duration in ticks) into an internal queue. The block plays them back-to-back with no gaps, returns velocity to zero when the queue drains, and grants position preset only while the axis is idle. A tick equals `TICK_DIV` clocks, matching the ramp-update period of `step_gen`.

## Interface
- `DEPTH`, 8: queue depth in segments; power of two, 2..64.
- `TICK_DIV`, 1000: clocks per duration tick.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `seg_valid`  in  1  push request.
- `seg_ready`  out  1  queue can accept; equals `count < DEPTH`, registered count.
- `seg_vel`  in  32  signed velocity for segment.
- `seg_dur`  in  32  unsigned duration in ticks.
- `setpos_req`  in  1  one-cycle request to preset position.
- `setpos_value`  in  32  signed preset value.
- `abort`  in  1  flush queue and stop.
- `velocity`  out  32  signed, to `step_gen.velocity`.
- `data_in`  out  32  signed, to `step_gen.data_in`.
- `set_position`  out  1  to `step_gen.set_position`.
- `busy`  out  1  state is RUN.
- `count`  out  clog2(DEPTH)+1  queued segments, excluding the active one.
- `seg_done`  out  1  one-cycle pulse when a segment completes or is skipped.
- `setpos_err`  out  1  one-cycle pulse when a preset request is rejected.

## Operation
- States: IDLE, RUN, SETPOS.
- Reset values:
  - state IDLE.
  - `velocity` = 0, `data_in` = 0, `set_position` = 0.
  - `count` = 0, `seg_done` = 0, `setpos_err` = 0, `busy` = 0.
  - `seg_ready` = 1.
  - Tick counter and remaining counter = 0.
- Push: accepted on a cycle with `seg_valid && seg_ready`. Pushes are accepted in every state.
- IDLE:
  - If `count > 0`, pop the head.
  - If `dur > 0`: `velocity <= seg_vel`, `remaining <= dur`, clear the tick counter, go to RUN.
  - If `dur == 0`: pop, pulse `seg_done`, leave `velocity` unchanged, stay in IDLE.
  - Otherwise, if `setpos_req`: `data_in <= setpos_value`, `set_position <= 1`, go to SETPOS.
  - Queue pop has priority over `setpos_req` in the same cycle; the request is then rejected with `setpos_err`.
- SETPOS: `set_position <= 0` and return to IDLE. `set_position` is high for exactly one clock.
- RUN:
  - The tick counter counts 0..TICK_DIV-1 and wraps.
  - At each wrap, `remaining` decrements.
  - When `remaining == 1` and the counter wraps, the segment ends and `seg_done` pulses.
    - Queue non-empty: pop the next segment in the same cycle and apply it as in IDLE. There is no idle cycle. A zero-duration next segment ends RUN with `velocity <= 0`.
    - Queue empty: `velocity <= 0`, go to IDLE.
  - `setpos_req` in RUN gives `setpos_err` only.
- `abort`, priority below `reset`, above everything else:
  - Next cycle: queue emptied, `velocity` = 0, `set_position` = 0, state IDLE.
  - No `seg_done`.
  - A push in the same cycle is dropped.
- Simultaneous push and pop: `count` is unchanged. `seg_ready` uses the pre-cycle count, so there is no push when full even if a pop occurs.
- Arithmetic: `remaining` is 32-bit unsigned. The tick counter is clog2(TICK_DIV) bits. `seg_vel` is passed through unmodified; clamping is done in `step_gen`.

## Timing
- All outputs are registered.
- Push in cycle N: `count` updates in N+1.
- IDLE pop in cycle N: `velocity` valid from N+1. It holds for exactly `dur*TICK_DIV` clocks, then changes to the next segment's velocity or to 0.
- `setpos_req` in cycle N while IDLE with an empty queue: `set_position` is high in N+1 only, and `data_in` is stable from N+1 onward.
- `abort` in N: outputs are at abort values in N+1. `seg_ready` is 1 in N+1.
- `reset` mid-segment: reset values apply the following cycle. The queued segments are discarded.

## Structure
- Package `motion_pkg`:
  - State enum (IDLE, RUN, SETPOS).
  - Segment record `{vel[31:0], dur[31:0]}`, 64 bits.
  - `TICK_DIV_DEFAULT` = 1000.
- Sub-module `seg_fifo`: synchronous FIFO of 64-bit segments with `DEPTH`, push/pop/flush, and `count`. It has no read latency (head is always presented). The controller FSM, tick counter and remaining counter live in `motion_seq`.

## Test plan
All scenarios use TICK_DIV=4, DEPTH=4.
- Push {vel=1000, dur=3}: `velocity` = 1000 for exactly 12 clocks, then 0. One `seg_done`, `busy` falls with the return to IDLE.
- Push {500,2}, {-700,1}, {0,0}, {300,1} back-to-back: velocity sequence 500×8 → -700×4 → 300 is not reached; the 0-duration segment drives velocity to 0 and returns to IDLE. The final {300,1} then plays 4 clocks. Four `seg_done` pulses in total.
- Fill the queue while RUN holds a segment of dur=100: `seg_ready` is 0 after 4 pushes and a fifth push is not accepted. Pop at segment end raises `seg_ready` the next cycle.
- `setpos_req` with value 12345 in IDLE and empty queue: `set_position` is high exactly one clock with `data_in` = 12345. The same request during RUN produces only `setpos_err`.
- `abort` mid-segment with 3 queued: next cycle `velocity` = 0, `count` = 0, state IDLE, no `seg_done`.
- `reset` asserted mid-RUN with push active: all outputs at reset values the next cycle. The queue is empty afterwards.
